dbram_gen: RTL

DBRAM_GEN -- requirements
Module: dbram_gen

---
 rtl/dbram_pkg.sv | 16 +
 rtl/dbram_clr_fsm.sv | 45 ++++
 rtl/dbram_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dbram_pkg.sv
// Shared types and constants for the dual-port byte-enable RAM with clear engine.
package dbram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int LAT_BASE   = 1;
    localparam int LAT_OUTREG = 2;

    function automatic int byte_cnt(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dbram_clr_fsm.sv
// Clear engine: walks every word once after reset, then hands the RAM to the ports.
module dbram_clr_fsm
    import dbram_pkg::*;
#(
    parameter int ADR_W        = 9,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    output logic             busy,
    output logic             clr_we,
    output logic [ADR_W-1:0] clr_adr
);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (state_q == CLEAR) begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            // Last word goes out this cycle; ports take over on the next one.
            if (cnt_q == {ADR_W{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign clr_adr = cnt_q;

endmodule

// File: rtl/dbram_gen.sv
// Dual-port byte-enable RAM, read-first across ports, A wins same-address write collisions.
// Define DBRAM_GEN_OUTREG_EN to add an output register stage per port (read latency 2).
module dbram_gen
    import dbram_pkg::*;
#(
    parameter int              DATA_W       = 32,
    parameter int              ADR_W        = 9,
    parameter string           INIT_FILE    = "none",
    parameter int              CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [DATA_W/8-1:0]      a_be,
    input  logic [ADR_W-1:0]         a_adr,
    input  logic [DATA_W-1:0]        a_wdat,
    output logic                     a_ack,
    output logic                     a_rvalid,
    output logic [DATA_W-1:0]        a_rdat,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [DATA_W/8-1:0]      b_be,
    input  logic [ADR_W-1:0]         b_adr,
    input  logic [DATA_W-1:0]        b_wdat,
    output logic                     b_ack,
    output logic                     b_rvalid,
    output logic [DATA_W-1:0]        b_rdat,
    output logic                     busy
);

    localparam int BE_W  = byte_cnt(DATA_W);
    localparam int DEPTH = 2 ** ADR_W;
`ifdef DBRAM_GEN_OUTREG_EN
    localparam int LAT = LAT_OUTREG;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic             clr_we;
    logic [ADR_W-1:0] clr_adr;

    dbram_clr_fsm #(
        .ADR_W        (ADR_W),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_clr_fsm (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        req, we, ack;
    logic [BE_W-1:0]   be   [2];
    logic [ADR_W-1:0]  adr  [2];
    logic [DATA_W-1:0] wdat [2];

    assign req     = {b_req, a_req};
    assign we      = {b_we, a_we};
    assign be[0]   = a_be;
    assign be[1]   = b_be;
    assign adr[0]  = a_adr;
    assign adr[1]  = b_adr;
    assign wdat[0] = a_wdat;
    assign wdat[1] = b_wdat;
    assign ack     = req & {2{~busy}};
    assign a_ack   = ack[0];
    assign b_ack   = ack[1];

    logic [1:0]        wr_en;
    logic [BE_W-1:0]   wr_be  [2];
    logic [ADR_W-1:0]  wr_adr [2];
    logic [DATA_W-1:0] wr_dat [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_en[p]  = ack[p] & we[p];
            wr_be[p]  = be[p];
            wr_adr[p] = adr[p];
            wr_dat[p] = wdat[p];
        end
        // The clear engine borrows port A's write path while busy.
        if (busy) begin
            wr_en[0]  = clr_we;
            wr_be[0]  = '1;
            wr_adr[0] = clr_adr;
            wr_dat[0] = CLR_VALUE;
        end
    end

    // B is written first so A's bytes overwrite it on a same-address collision.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en[1] && wr_be[1][i]) begin
                mem_q[wr_adr[1]][8*i +: 8] <= wr_dat[1][8*i +: 8];
            end
            if (wr_en[0] && wr_be[0][i]) begin
                mem_q[wr_adr[0]][8*i +: 8] <= wr_dat[0][8*i +: 8];
            end
        end
    end

    logic [DATA_W-1:0] rdat_q [2][LAT];
    logic [DATA_W-1:0] rdat_d [2][LAT];
    logic              rvld_q [2][LAT];
    logic              rvld_d [2][LAT];

    // Stage 0 samples the array before this cycle's writes land (read-first);
    // later stages only advance when the previous stage holds valid data.
    always_comb begin
        rdat_d = rdat_q;
        rvld_d = rvld_q;
        for (int p = 0; p < 2; p++) begin
            rvld_d[p][0] = ack[p] & ~we[p];
            if (ack[p] && !we[p]) begin
                rdat_d[p][0] = mem_q[adr[p]];
            end
            for (int s = 1; s < LAT; s++) begin
                rvld_d[p][s] = rvld_q[p][s-1];
                if (rvld_q[p][s-1]) begin
                    rdat_d[p][s] = rdat_q[p][s-1];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < LAT; s++) begin
                    rvld_q[p][s] <= 1'b0;
                    rdat_q[p][s] <= '0;
                end
            end
        end else begin
            rvld_q <= rvld_d;
            rdat_q <= rdat_d;
        end
    end

    assign a_rvalid = rvld_q[0][LAT-1];
    assign a_rdat   = rdat_q[0][LAT-1];
    assign b_rvalid = rvld_q[1][LAT-1];
    assign b_rdat   = rdat_q[1][LAT-1];

endmodule
